// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 command sequencer.
// The init ROM is only referenced when LCD_INIT_EN is defined.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_EXEC
`ifdef LCD_INIT_EN
      , ST_INIT_WAIT
`endif
   } lcd_state_e;

   localparam int BIT_ON = 31;
   localparam int BIT_EN = 10;
   localparam int BIT_RS = 9;
   localparam int BIT_RW = 8;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   localparam int INIT_LEN = 6;
   localparam logic [0:INIT_LEN-1][7:0] INIT_SEQ = {
      8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06
   };

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Clear and home need the long execution wait; everything else is short.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO for queued LCD writes ({rs, byte}).
// DEPTH must be a power of two so the pointers wrap by overflow.
module lcd_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Replays queued CPU byte writes onto HD44780 pins with setup/EN/hold/exec timing.
// Define LCD_INIT_EN to add the power-on wait and fixed init command sequence.
//
// state      | meaning
// INIT_WAIT  | power-on delay before init sequence (LCD_INIT_EN only)
// IDLE       | waiting for an init command or a FIFO entry
// SETUP      | data/RS driven, EN low
// PULSE      | EN high
// HOLD       | EN low, data/RS held
// EXEC       | waiting for the LCD to finish the command
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 12,
   parameter int HOLD_CYC  = 2,
   parameter int EXEC_CYC  = 2000,
   parameter int LONG_CYC  = 82000,
   parameter int INIT_CYC  = 750000
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_wr,
   input  logic [31:0]              i_wdata,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_busy,
   output logic                     o_overflow,
   output logic [7:0]               o_lcd_data,
   output logic                     o_lcd_rs,
   output logic                     o_lcd_rw,
   output logic                     o_lcd_en,
   output logic                     o_lcd_on
);

   localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC), max_int(HOLD_CYC, EXEC_CYC)),
                                    max_int(LONG_CYC, INIT_CYC));
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // Phases last exactly N cycles: load N-1 and leave on the cycle the count is zero.
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_CYC - 1);

   lcd_state_e       state;
   lcd_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [7:0]       data_nxt;
   logic             rs_nxt;
   logic             en_nxt;

   logic             push_req;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [8:0]       fifo_rdata;
   logic             unused_wdata;

`ifdef LCD_INIT_EN
   localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(INIT_CYC - 1);
   localparam int IW = $clog2(INIT_LEN + 1);

   logic [IW-1:0] init_idx;
   logic [IW-1:0] init_idx_nxt;
   logic          init_pending;

   assign init_pending = (init_idx != IW'(INIT_LEN));
`endif

   assign push_req     = i_wr && i_wdata[BIT_EN];
   assign o_full       = fifo_full;
   assign o_lcd_rw     = 1'b0;
   assign unused_wdata = ^{i_wdata[30:11], i_wdata[BIT_RW]};

`ifdef LCD_INIT_EN
   assign o_busy = (state != ST_IDLE) || !fifo_empty || init_pending;
`else
   assign o_busy = (state != ST_IDLE) || !fifo_empty;
`endif

   lcd_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (push_req),
      .pop   (fifo_pop),
      .wdata ({i_wdata[BIT_RS], i_wdata[7:0]}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (o_level)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      data_nxt  = o_lcd_data;
      rs_nxt    = o_lcd_rs;
      en_nxt    = o_lcd_en;
      fifo_pop  = 1'b0;
`ifdef LCD_INIT_EN
      init_idx_nxt = init_idx;
`endif
      case (state)
`ifdef LCD_INIT_EN
         ST_INIT_WAIT: begin
            if (cnt == '0) state_nxt = ST_IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end
`endif
         ST_IDLE: begin
`ifdef LCD_INIT_EN
            // Init commands take priority; FIFO entries wait behind them.
            if (init_pending) begin
               data_nxt     = INIT_SEQ[init_idx];
               rs_nxt       = 1'b0;
               init_idx_nxt = init_idx + 1'b1;
               cnt_nxt      = LD_SETUP;
               state_nxt    = ST_SETUP;
            end else
`endif
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               rs_nxt    = fifo_rdata[8];
               data_nxt  = fifo_rdata[7:0];
               cnt_nxt   = LD_SETUP;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               en_nxt    = 1'b1;
               cnt_nxt   = LD_PULSE;
               state_nxt = ST_PULSE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_PULSE: begin
            if (cnt == '0) begin
               en_nxt    = 1'b0;
               cnt_nxt   = LD_HOLD;
               state_nxt = ST_HOLD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               cnt_nxt   = is_long_cmd(o_lcd_rs, o_lcd_data) ? LD_LONG : LD_EXEC;
               state_nxt = ST_EXEC;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_EXEC: begin
            if (cnt == '0) state_nxt = ST_IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
`ifdef LCD_INIT_EN
         state    <= ST_INIT_WAIT;
         cnt      <= LD_INIT;
         init_idx <= '0;
`else
         state    <= ST_IDLE;
         cnt      <= '0;
`endif
         o_lcd_data <= '0;
         o_lcd_rs   <= 1'b0;
         o_lcd_en   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         o_lcd_data <= data_nxt;
         o_lcd_rs   <= rs_nxt;
         o_lcd_en   <= en_nxt;
`ifdef LCD_INIT_EN
         init_idx   <= init_idx_nxt;
`endif
      end
   end

   // ON is a direct register image bit, never queued; overflow ignores a same-cycle pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_lcd_on   <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         if (i_wr)                  o_lcd_on   <= i_wdata[BIT_ON];
         if (push_req && fifo_full) o_overflow <= 1'b1;
      end
   end

endmodule
